// File: rtl/chan_eq_param_if.sv
// Sample/result bus for chan_eq_param: runtime config, input sample stream and equalised output stream.
interface chan_eq_param_if #(
   parameter int DW        = 16,
   parameter int LEN_SHIFT = 6
);
   localparam int N = 1 << LEN_SHIFT;

   // Strobe semantics: sample_in_stb qualifies sample_in, lts_ref and sub_mask for a single
   // enabled cycle and there is no back-pressure; out_stb qualifies prod_*, mag_sq and out_bin.
   logic                      enable;
   logic                      start;
   logic [N-1:0]              lts_ref;
   logic [N-1:0]              sub_mask;
   logic [2*DW-1:0]           sample_in;
   logic                      sample_in_stb;
   logic signed [2*DW:0]      prod_i;
   logic signed [2*DW:0]      prod_q;
   logic [2*DW-1:0]           mag_sq;
   logic [LEN_SHIFT-1:0]      out_bin;
   logic                      out_stb;
   logic                      sym_done;
   logic                      est_valid;

   modport master (
      output enable, start, lts_ref, sub_mask, sample_in, sample_in_stb,
      input  prod_i, prod_q, mag_sq, out_bin, out_stb, sym_done, est_valid
   );

   modport slave (
      input  enable, start, lts_ref, sub_mask, sample_in, sample_in_stb,
      output prod_i, prod_q, mag_sq, out_bin, out_stb, sym_done, est_valid
   );
endinterface

// File: rtl/chan_eq_param.sv
// Parametrised OFDM channel estimator/equaliser: averages 2^AVG_SHIFT sign-corrected LTS symbols
// into H[k], then streams x*conj(H) and |H|^2 for masked data bins through a 2-stage pipeline.
module chan_eq_param #(
   parameter int DW        = 16,
   parameter int LEN_SHIFT = 6,
   parameter int AVG_SHIFT = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   chan_eq_param_if.slave        bus,
   output logic [1:0]            dbg_state
);
   localparam int N  = 1 << LEN_SHIFT;
   localparam int AW = DW + AVG_SHIFT;
   localparam int SW = AVG_SHIFT + 1;
   localparam int PW = 2*DW + 1;
   localparam logic [LEN_SHIFT-1:0] BIN_LAST = '1;
   localparam logic [SW-1:0]        SYM_LAST = SW'((1 << AVG_SHIFT) - 1);
   localparam logic signed [DW-1:0] S_MIN    = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] S_MAX    = {1'b0, {(DW-1){1'b1}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EST = 2'd1, S_EQ = 2'd2} state_t;

   state_t               r_state, w_state_nxt;
   logic [LEN_SHIFT-1:0] r_bin, w_bin_nxt;
   logic [SW-1:0]        r_sym, w_sym_nxt;
   logic                 w_acc_we, w_eq_take, w_eq_last;

   logic signed [AW-1:0] r_acc_i [N];
   logic signed [AW-1:0] r_acc_q [N];

   logic signed [DW-1:0] w_x_i, w_x_q, w_s_i, w_s_q, w_h_i, w_h_q;
   logic signed [AW-1:0] w_rd_i, w_rd_q, w_sh_i, w_sh_q, w_new_i, w_new_q;
   logic                 w_neg;

   logic                 r_v1, r_last1;
   logic signed [DW-1:0] r_x_i, r_x_q, r_h_i, r_h_q;
   logic [LEN_SHIFT-1:0] r_bin1;
   logic signed [PW-1:0] w_pi, w_pq, w_mag;

   logic                 r_out_stb, r_sym_done;
   logic signed [PW-1:0] r_prod_i, r_prod_q;
   logic [2*DW-1:0]      r_mag_sq;
   logic [LEN_SHIFT-1:0] r_out_bin;

   // Reference -1 negates the sample; the most negative code saturates instead of wrapping.
   assign w_x_i = bus.sample_in[2*DW-1:DW];
   assign w_x_q = bus.sample_in[DW-1:0];
   assign w_neg = bus.lts_ref[r_bin];
   assign w_s_i = !w_neg ? w_x_i : ((w_x_i == S_MIN) ? S_MAX : -w_x_i);
   assign w_s_q = !w_neg ? w_x_q : ((w_x_q == S_MIN) ? S_MAX : -w_x_q);

   assign w_rd_i  = r_acc_i[r_bin];
   assign w_rd_q  = r_acc_q[r_bin];
   assign w_new_i = ((r_sym == '0) ? '0 : w_rd_i) + AW'(w_s_i);
   assign w_new_q = ((r_sym == '0) ? '0 : w_rd_q) + AW'(w_s_q);

   // The stored sum is scaled on read, so H[k] is the floor of the mean without a rewrite pass.
   assign w_sh_i = w_rd_i >>> AVG_SHIFT;
   assign w_sh_q = w_rd_q >>> AVG_SHIFT;
   assign w_h_i  = w_sh_i[DW-1:0];
   assign w_h_q  = w_sh_q[DW-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_bin_nxt   = r_bin;
      w_sym_nxt   = r_sym;
      w_acc_we    = 1'b0;
      w_eq_take   = 1'b0;
      w_eq_last   = 1'b0;
      if (bus.enable) begin
         if (bus.start) begin
            w_state_nxt = S_EST;
            w_bin_nxt   = '0;
            w_sym_nxt   = '0;
         end else if (bus.sample_in_stb) begin
            case (r_state)
               S_EST: begin
                  w_acc_we  = 1'b1;
                  w_bin_nxt = r_bin + 1'b1;
                  if (r_bin == BIN_LAST) begin
                     if (r_sym == SYM_LAST) begin
                        w_state_nxt = S_EQ;
                        w_sym_nxt   = '0;
                     end else begin
                        w_sym_nxt = r_sym + 1'b1;
                     end
                  end
               end
               S_EQ: begin
                  w_eq_take = 1'b1;
                  w_eq_last = (r_bin == BIN_LAST);
                  w_bin_nxt = r_bin + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_bin   <= '0;
         r_sym   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_bin   <= w_bin_nxt;
         r_sym   <= w_sym_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (w_acc_we) begin
         r_acc_i[r_bin] <= w_new_i;
         r_acc_q[r_bin] <= w_new_q;
      end
   end

   assign w_pi  = PW'(r_x_i) * PW'(r_h_i) + PW'(r_x_q) * PW'(r_h_q);
   assign w_pq  = PW'(r_x_q) * PW'(r_h_i) - PW'(r_x_i) * PW'(r_h_q);
   assign w_mag = PW'(r_h_i) * PW'(r_h_i) + PW'(r_h_q) * PW'(r_h_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_v1       <= 1'b0;
         r_last1    <= 1'b0;
         r_x_i      <= '0;
         r_x_q      <= '0;
         r_h_i      <= '0;
         r_h_q      <= '0;
         r_bin1     <= '0;
         r_out_stb  <= 1'b0;
         r_sym_done <= 1'b0;
         r_prod_i   <= '0;
         r_prod_q   <= '0;
         r_mag_sq   <= '0;
         r_out_bin  <= '0;
      end else if (bus.enable) begin
         r_v1       <= w_eq_take & bus.sub_mask[r_bin];
         r_last1    <= w_eq_last;
         r_out_stb  <= r_v1;
         r_sym_done <= r_last1;
         if (w_eq_take) begin
            r_x_i  <= w_x_i;
            r_x_q  <= w_x_q;
            r_h_i  <= w_h_i;
            r_h_q  <= w_h_q;
            r_bin1 <= r_bin;
         end
         if (r_v1) begin
            r_prod_i  <= w_pi;
            r_prod_q  <= w_pq;
            r_mag_sq  <= w_mag[2*DW-1:0];
            r_out_bin <= r_bin1;
         end
      end
   end

   assign bus.prod_i    = r_prod_i;
   assign bus.prod_q    = r_prod_q;
   assign bus.mag_sq    = r_mag_sq;
   assign bus.out_bin   = r_out_bin;
   assign bus.out_stb   = r_out_stb & bus.enable;
   assign bus.sym_done  = r_sym_done & bus.enable;
   assign bus.est_valid = (r_state == S_EQ);
   assign dbg_state     = r_state;
endmodule
